// File: rtl/debug_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : debug_dump_unit
// Purpose  : UART-driven run/step/halt control with a PC/register/memory dump;
//            defining DBG_CYCLE_COUNT_EN appends a saturating cpu_enable cycle counter.
// Revision : 1.0
// ============================================================================
module debug_dump_unit #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int MEM_WORDS = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              cpu_halt,
    input  logic [DATA_W-1:0] pc_value,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              cpu_enable,
    output logic              busy
);
    typedef enum logic [2:0] {
        IDLE, RUN, STEP, DUMP_PC, DUMP_REG, DUMP_MEM, DUMP_CNT, SEND
    } state_t;

    localparam int                c_bytes     = DATA_W / 8;
    localparam int                c_bc_w      = (c_bytes > 1) ? $clog2(c_bytes) : 1;
    localparam logic [c_bc_w-1:0] c_last_byte = c_bc_w'(c_bytes - 1);
    localparam logic [ADDR_W-1:0] c_last_reg  = ADDR_W'((NUM_REGS  > 0) ? NUM_REGS  - 1 : 0);
    localparam logic [ADDR_W-1:0] c_last_mem  = ADDR_W'((MEM_WORDS > 0) ? MEM_WORDS - 1 : 0);

`ifdef DBG_CYCLE_COUNT_EN
    localparam state_t c_after_mem = DUMP_CNT;
`else
    localparam state_t c_after_mem = IDLE;
`endif
    // Empty sections (parameter 0) are skipped at elaboration time.
    localparam state_t c_after_regs = (MEM_WORDS > 0) ? DUMP_MEM : c_after_mem;
    localparam state_t c_after_pc   = (NUM_REGS  > 0) ? DUMP_REG : c_after_regs;

    state_t              r_state, w_state_next;
    state_t              r_ret, w_ret_next;
    logic [DATA_W-1:0]   r_shift;
    logic [c_bc_w-1:0]   r_byte_cnt;
    logic                w_hs;
    logic                w_last_byte;

    assign w_hs        = tx_valid & tx_ready;
    assign w_last_byte = (r_byte_cnt == c_last_byte);
    assign tx_data     = r_shift[DATA_W-1 -: 8];
    assign cpu_enable  = (r_state == RUN) || (r_state == STEP);
    assign busy        = (r_state != IDLE);

`ifdef DBG_CYCLE_COUNT_EN
    logic [DATA_W-1:0] r_cycle_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cycle_cnt <= '0;
        end else if (cpu_enable && (r_cycle_cnt != '1)) begin
            r_cycle_cnt <= r_cycle_cnt + DATA_W'(1);
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_ret   <= IDLE;
        end else begin
            r_state <= w_state_next;
            r_ret   <= w_ret_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ret_next   = r_ret;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h63:   w_state_next = RUN;
                        8'h73:   w_state_next = STEP;
                        8'h64:   w_state_next = DUMP_PC;
                        default: w_state_next = IDLE;
                    endcase
                end
            end
            RUN:      if (cpu_halt) w_state_next = DUMP_PC;
            STEP:     w_state_next = DUMP_PC;
            DUMP_PC: begin
                w_state_next = SEND;
                w_ret_next   = c_after_pc;
            end
            DUMP_REG: begin
                w_state_next = SEND;
                w_ret_next   = (reg_addr == c_last_reg) ? c_after_regs : DUMP_REG;
            end
            DUMP_MEM: begin
                w_state_next = SEND;
                w_ret_next   = (mem_addr == c_last_mem) ? c_after_mem : DUMP_MEM;
            end
            DUMP_CNT: begin
                w_state_next = SEND;
                w_ret_next   = IDLE;
            end
            SEND:     if (w_hs && w_last_byte) w_state_next = r_ret;
            default:  w_state_next = IDLE;
        endcase
    end

    // Each DUMP_* cycle latches one word; tx_valid follows in the next cycle.
    // mem_addr already points at the word being latched, since the RAM has
    // seen it for at least one edge (reset at DUMP_PC, advanced at each latch).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            tx_valid   <= 1'b0;
            reg_addr   <= '0;
            mem_addr   <= '0;
        end else begin
            case (r_state)
                DUMP_PC: begin
                    r_shift    <= pc_value;
                    r_byte_cnt <= '0;
                    tx_valid   <= 1'b1;
                    reg_addr   <= '0;
                    mem_addr   <= '0;
                end
                DUMP_REG: begin
                    r_shift    <= reg_data;
                    r_byte_cnt <= '0;
                    tx_valid   <= 1'b1;
                    if (reg_addr != c_last_reg) reg_addr <= reg_addr + ADDR_W'(1);
                end
                DUMP_MEM: begin
                    r_shift    <= mem_data;
                    r_byte_cnt <= '0;
                    tx_valid   <= 1'b1;
                    if (mem_addr != c_last_mem) mem_addr <= mem_addr + ADDR_W'(1);
                end
                DUMP_CNT: begin
`ifdef DBG_CYCLE_COUNT_EN
                    r_shift    <= r_cycle_cnt;
`else
                    r_shift    <= '0;
`endif
                    r_byte_cnt <= '0;
                    tx_valid   <= 1'b1;
                end
                SEND: begin
                    if (w_hs) begin
                        if (w_last_byte) begin
                            tx_valid <= 1'b0;
                        end else begin
                            r_shift    <= r_shift << 8;
                            r_byte_cnt <= r_byte_cnt + c_bc_w'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_dump_unit
// Purpose  : Self-checking bench: command table, directed corner sequences and
//            randomized dumps compared against a byte-stream reference model.
// Revision : 1.0
// ============================================================================
module tb_debug_dump_unit;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int MW = 32;
    localparam int AW = 5;
    localparam int NB = DW / 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          cpu_halt = 1'b0;
    logic [DW-1:0] pc_value = '0;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          cpu_enable;
    logic          busy;

    debug_dump_unit #(.DATA_W(DW), .NUM_REGS(NR), .MEM_WORDS(MW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_halt(cpu_halt), .pc_value(pc_value), .reg_addr(reg_addr),
        .reg_data(reg_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_enable(cpu_enable), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // CPU-side models: combinational register file, one-cycle-latency RAM.
    logic [DW-1:0] reg_file [0:NR-1];
    logic [DW-1:0] mem_arr  [0:MW-1];
    assign reg_data = reg_file[reg_addr];
    always @(posedge CLK) mem_data <= mem_arr[mem_addr];

    typedef struct {
        logic [7:0] cmd;
        logic       exp_busy;
        logic       exp_en;
    } cmd_vec_t;

    int         checks = 0;
    int         errors = 0;
    int         en_count = 0;
    int         cyc = 0;
    int         stab_viol = 0;
    int         model_cyc = 0;
    bit         rand_ready = 1'b0;
    logic [7:0] cap[$];
    int         cap_cyc[$];
    logic [7:0] exp_q[$];
    bit         prev_wait = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Observer at the falling edge: counts enables, records accepted bytes.
    initial forever begin
        @(negedge CLK);
        cyc++;
        if (cpu_enable === 1'b1) en_count++;
        if (tx_valid === 1'b1 && prev_wait && tx_data !== prev_data) stab_viol++;
        prev_wait = (tx_valid === 1'b1) && (tx_ready === 1'b0);
        prev_data = tx_data;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            cap.push_back(tx_data);
            cap_cyc.push_back(cyc);
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        tx_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] junk_byte();
        case ($urandom % 4)
            0:       return 8'h63;
            1:       return 8'h73;
            2:       return 8'h64;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic void push_word(input logic [DW-1:0] w);
        for (int b = NB - 1; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endfunction

    // Expected dump: pc, every register, every memory word, optional counter.
    function automatic void build_exp();
        exp_q.delete();
        push_word(pc_value);
        for (int i = 0; i < NR; i++) push_word(reg_file[i]);
        for (int i = 0; i < MW; i++) push_word(mem_arr[i]);
`ifdef DBG_CYCLE_COUNT_EN
        push_word(DW'(model_cyc));
`endif
    endfunction

    task automatic randomize_state();
        pc_value = DW'($urandom);
        for (int i = 0; i < NR; i++) reg_file[i] = DW'($urandom);
        for (int i = 0; i < MW; i++) mem_arr[i] = DW'($urandom);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        model_cyc = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        rx_valid = 1'b1;
        rx_data  = c;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit junk);
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(posedge CLK); #1;
            n++;
            if (junk && busy === 1'b1) begin
                rx_valid = 1'($urandom % 2);
                rx_data  = junk_byte();
            end else begin
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
        check("idle_timeout", 64'(n < 5000), 64'd1);
    endtask

    task automatic finish_dump(input int s0, input int e0, input int v0,
                               input int exp_en, input bit junk);
        int mism = 0;
        build_exp();
        wait_idle(junk);
        check("cpu_enable_cycles", 64'(en_count - e0), 64'(exp_en));
        check("dump_length", 64'(cap.size() - s0), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (s0 + i >= cap.size() || cap[s0 + i] !== exp_q[i]) mism++;
        end
        check("dump_stream", 64'(mism), 64'd0);
        check("tx_data_stable", 64'(stab_viol - v0), 64'd0);
        @(posedge CLK); #1;
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_cmd(input logic [7:0] c, input int n, input bit junk);
        int s0 = cap.size();
        int e0 = en_count;
        int v0 = stab_viol;
        int exp_en = 0;
        send_cmd(c);
        if (c == 8'h63) begin
            for (int i = 1; i < n; i++) begin
                if (junk) begin
                    rx_valid = 1'($urandom % 2);
                    rx_data  = junk_byte();
                end
                @(posedge CLK); #1;
            end
            rx_valid = 1'b0;
            cpu_halt = 1'b1;
            @(posedge CLK); #1;
            cpu_halt = 1'b0;
            model_cyc += n;
            exp_en = n;
        end else if (c == 8'h73) begin
            model_cyc += 1;
            exp_en = 1;
        end
        finish_dump(s0, e0, v0, exp_en, junk);
    endtask

    initial begin
        cmd_vec_t vecs[7];
        int s0, e0, v0, bad, n;

        vecs[0] = '{8'h63, 1'b1, 1'b1};
        vecs[1] = '{8'h73, 1'b1, 1'b1};
        vecs[2] = '{8'h64, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h43, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h65, 1'b0, 1'b0};

        randomize_state();
        @(posedge CLK); #1;
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_reg_addr", 64'(reg_addr), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        RESET = 1'b0;

        foreach (vecs[i]) begin
            send_cmd(vecs[i].cmd);
            check("cmd_busy", 64'(busy), 64'(vecs[i].exp_busy));
            check("cmd_cpu_enable", 64'(cpu_enable), 64'(vecs[i].exp_en));
            do_reset();
        end

        // Plain dump, transmitter always ready.
        s0 = cap.size();
        run_cmd(8'h64, 0, 1'b0);
        check("pc_first_word", 64'({cap[s0], cap[s0+1], cap[s0+2], cap[s0+3]}), 64'(pc_value));
        bad = 0;
        for (int w = 0; w < 1 + NR + MW; w++)
            for (int b = 1; b < NB; b++)
                if (cap_cyc[s0 + w*NB + b] != cap_cyc[s0 + w*NB + b - 1] + 1) bad++;
        check("back_to_back_bytes", 64'(bad), 64'd0);

        // Single step: one enable cycle, then the dump starts.
        randomize_state();
        s0 = cap.size(); e0 = en_count; v0 = stab_viol;
        send_cmd(8'h73);
        check("step_en_first", 64'(cpu_enable), 64'd1);
        @(posedge CLK); #1;
        check("step_en_after", 64'(cpu_enable), 64'd0);
        check("step_busy_after", 64'(busy), 64'd1);
        model_cyc += 1;
        finish_dump(s0, e0, v0, 1, 1'b0);

        // Run for 10 cycles, halt triggers an automatic dump.
        randomize_state();
        run_cmd(8'h63, 10, 1'b0);

        // Halt and 'c' in the same cycle: one RUN cycle, then dump.
        randomize_state();
        s0 = cap.size(); e0 = en_count; v0 = stab_viol;
        cpu_halt = 1'b1;
        send_cmd(8'h63);
        check("halt_c_en", 64'(cpu_enable), 64'd1);
        @(posedge CLK); #1;
        check("halt_c_en_after", 64'(cpu_enable), 64'd0);
        check("halt_c_busy", 64'(busy), 64'd1);
        cpu_halt = 1'b0;
        model_cyc += 1;
        finish_dump(s0, e0, v0, 1, 1'b0);

        // Random back-pressure with a known register 0 value.
        randomize_state();
        reg_file[0] = 32'hA1B2C3D4;
        rand_ready = 1'b1;
        s0 = cap.size();
        run_cmd(8'h64, 0, 1'b0);
        check("reg0_bytes", 64'({cap[s0+4], cap[s0+5], cap[s0+6], cap[s0+7]}), 64'hA1B2C3D4);
        rand_ready = 1'b0;

        // Reset in the middle of the memory section, then a fresh dump.
        randomize_state();
        s0 = cap.size();
        send_cmd(8'h64);
        n = 0;
        while (cap.size() - s0 < NB*(1 + NR) + 10 && n < 3000) begin
            @(posedge CLK); #1;
            n++;
        end
        check("mid_dump_timeout", 64'(n < 3000), 64'd1);
        RESET = 1'b1;
        #1;
        check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_tx_data", 64'(tx_data), 64'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_cyc = 0;
        randomize_state();
        run_cmd(8'h64, 0, 1'b0);

        // Run for 7 cycles (counter value when the cycle counter is built in).
        randomize_state();
        run_cmd(8'h63, 7, 1'b0);

        for (int it = 0; it < 8; it++) begin
            int k;
            randomize_state();
            rand_ready = 1'($urandom % 2);
            k = int'($urandom % 3);
            if (k == 0)      run_cmd(8'h64, 0, 1'b1);
            else if (k == 1) run_cmd(8'h73, 1, 1'b1);
            else             run_cmd(8'h63, int'($urandom_range(1, 20)), 1'b1);
        end
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/debug_dump_unit.md
DEBUG_DUMP_UNIT -- requirements
Module: debug_dump_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the dumped CPU word, a multiple of 8.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning the number of register-file entries dumped.
REQ-003 The block SHALL have parameter MEM_WORDS, default 32, meaning the number of data-memory words dumped from address 0.
REQ-004 The block SHALL have parameter ADDR_W, default 5, meaning the address width of both read ports; 2**ADDR_W >= max(NUM_REGS, MEM_WORDS).
REQ-005 The ports SHALL be:
CLK  in  1  single clock; all state updates on the rising edge.
RESET  in  1  asynchronous, active-high reset.
rx_data  in  8  command byte from the UART receiver.
rx_valid  in  1  one-cycle strobe; rx_data is valid.
tx_data  out  8  byte to the UART transmitter.
tx_valid  out  1  tx_data is valid; held until accepted.
tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
cpu_halt  in  1  CPU has executed its halt instruction.
pc_value  in  DATA_W  current program counter.
reg_addr  out  ADDR_W  register-file debug read address.
reg_data  in  DATA_W  register-file read data, combinational from reg_addr.
mem_addr  out  ADDR_W  data-memory debug read address.
mem_data  in  DATA_W  data-memory read data, valid one cycle after mem_addr.
cpu_enable  out  1  pipeline clock enable.
busy  out  1  high in every state except IDLE.

Function
REQ-006 The FSM SHALL have states IDLE, RUN, STEP, DUMP_PC, DUMP_REG, DUMP_MEM, DUMP_CNT, SEND.
REQ-007 In IDLE, an rx_valid with byte 0x63 ('c') SHALL enter RUN, byte 0x73 ('s') SHALL enter STEP, and byte 0x64 ('d') SHALL enter DUMP_PC; any other byte SHALL be ignored.
REQ-008 cpu_enable SHALL be high in every RUN cycle and in exactly one STEP cycle, and low in all other states.
REQ-009 RUN SHALL remain active until cpu_halt is sampled high, then go to DUMP_PC the next cycle; rx_valid SHALL be ignored while in RUN.
REQ-010 STEP SHALL last one cycle and then go to DUMP_PC.
REQ-011 A dump SHALL send, in order: pc_value; registers 0..NUM_REGS-1; memory words 0..MEM_WORDS-1; the cycle counter if DBG_CYCLE_COUNT_EN is defined. The FSM SHALL then return to IDLE.
REQ-012 Each word SHALL be latched into a DATA_W shift register and sent as DATA_W/8 bytes, most significant byte first, via SEND.
REQ-013 For each memory word, the block SHALL drive mem_addr one cycle before latching mem_data.
REQ-014 tx_valid SHALL rise in the cycle after a word is latched, and tx_data SHALL stay stable until the handshake.
REQ-015 The next byte SHALL be presented in the cycle after the handshake; back-to-back tx_ready SHALL yield one byte per cycle.
REQ-016 Address counters SHALL stop at NUM_REGS-1 and MEM_WORDS-1 and SHALL never wrap past them; a parameter value of 0 SHALL skip that section.
REQ-017 rx_valid during any dump state SHALL be ignored, with no buffering.
REQ-018 When cpu_halt and a 'c' byte arrive in the same IDLE cycle, the block SHALL enter RUN, and the halt SHALL be honoured on the next cycle.
REQ-019 busy SHALL be low exactly in IDLE.

Reset
REQ-020 RESET SHALL act immediately, including in the middle of a dump.
REQ-021 On RESET, the state SHALL go to IDLE, and tx_valid, cpu_enable and busy SHALL be 0.
REQ-022 On RESET, tx_data, reg_addr, mem_addr, the shift register and the byte and word counters SHALL be 0.
REQ-023 A byte in flight SHALL be dropped on RESET, with no partial completion.

Configuration
REQ-024 When DBG_CYCLE_COUNT_EN is defined, a DATA_W cycle counter SHALL increment on every cpu_enable-high cycle, saturate at all-ones, clear on RESET, and be sent last in each dump.
REQ-025 When DBG_CYCLE_COUNT_EN is undefined, no counter SHALL exist, and a dump SHALL be exactly (1+NUM_REGS+MEM_WORDS)*DATA_W/8 bytes.

Verification
REQ-026 Defaults, macro off, tx_ready tied high, 'd' in IDLE -> exactly 260 bytes; the first 4 bytes equal pc_value MSB first; then IDLE with busy=0.
REQ-027 's' -> cpu_enable high for exactly 1 cycle; then a dump begins.
REQ-028 'c', with cpu_halt raised after 10 cycles -> cpu_enable high for 10 cycles, then an automatic dump.
REQ-029 tx_ready toggled randomly with reg_data=0xA1B2C3D4 -> bytes A1,B2,C3,D4; tx_data stable while tx_valid=1 and tx_ready=0.
REQ-030 RESET asserted mid-memory dump -> tx_valid=0 the same cycle; the next 'd' restarts from pc_value.
REQ-031 Macro on, 'c' with halt after 7 cycles -> 264 bytes; the last 4 bytes equal 0x00000007.
